// File: rtl/toe_hash_pkg.sv
// Shared definitions for the TOE cuckoo hash pipeline.
//   - default key/hash geometry and generator seed
//   - xorshift step used to fill the mask table after reset
//   - row-address width helper
//   - FSM state encoding
package toe_hash_pkg;

  localparam int K_DEF    = 97;
  localparam int H_DEF    = 48;
  localparam int NH_DEF   = 2;
  localparam int SEED_DEF = 1;

  // Widest key the generator function handles; callers pass their real
  // width and the result is confined to that many low bits.
  localparam int KMAX = 256;
  typedef logic [KMAX-1:0] gen_t;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // x ^= x<<13; x ^= x>>7; x ^= x<<17, all shifts truncated to k bits.
  function automatic gen_t xs_step(input gen_t x, input int k);
    gen_t m, y;
    m = {KMAX{1'b1}} >> (KMAX - k);
    y = x & m;
    y = (y ^ (y << 13)) & m;
    y = y ^ (y >> 7);
    y = (y ^ (y << 17)) & m;
    return y;
  endfunction

endpackage

// File: rtl/toe_hash_pipe_if.sv
// Bus bundle for toe_hash_pipe: key stream in, hash stream out, mask-row
// config port and the init-done flag.
//   slave  : the hash pipeline side
//   master : the producer/consumer/config side
interface toe_hash_pipe_if import toe_hash_pkg::*; #(
  parameter int K  = K_DEF,
  parameter int H  = H_DEF,
  parameter int NH = NH_DEF
);
  localparam int AW = addr_w(NH*H);

  logic [K-1:0]    piKey_Data;
  logic [7:0]      piKey_Tag;
  logic            piKey_V;
  logic            poKey_R;
  logic [NH*H-1:0] poHash_Data;
  logic [7:0]      poHash_Tag;
  logic            poHash_V;
  logic            piHash_R;
  logic            piCfg_We;
  logic [AW-1:0]   piCfg_Addr;
  logic [K-1:0]    piCfg_Data;
  logic            poInitDone;

  modport slave (
    input  piKey_Data, piKey_Tag, piKey_V, piHash_R,
           piCfg_We, piCfg_Addr, piCfg_Data,
    output poKey_R, poHash_Data, poHash_Tag, poHash_V, poInitDone
  );

  modport master (
    output piKey_Data, piKey_Tag, piKey_V, piHash_R,
           piCfg_We, piCfg_Addr, piCfg_Data,
    input  poKey_R, poHash_Data, poHash_Tag, poHash_V, poInitDone
  );

endinterface

// File: rtl/toe_hash_row.sv
// One mask row of the hash: parity of (key AND row) computed separately for
// the low half key[K/2-1:0] and the high half key[K-1:K/2]. The caller
// registers both and XORs them a stage later.
//   key    : key under hash
//   row    : mask row
//   lo_par : parity over the low half
//   hi_par : parity over the high half
module toe_hash_row import toe_hash_pkg::*; #(
  parameter int K = K_DEF
) (
  input  logic [K-1:0] key,
  input  logic [K-1:0] row,
  output logic         lo_par,
  output logic         hi_par
);
  localparam int KL = K / 2;

  assign lo_par = ^(key[KL-1:0] & row[KL-1:0]);
  assign hi_par = ^(key[K-1:KL] & row[K-1:KL]);

endmodule

// File: rtl/toe_hash_pipe.sv
// Multi-way XOR-mask hash pipeline for the TOE cuckoo table.
// After reset the mask table (NH*H rows of K bits) is filled one row per
// cycle from an xorshift generator; keys are then hashed through two
// register stages (split parities, then combine), one key per cycle, with
// full valid/ready backpressure. Rows can be overwritten at run time.
//   piClk, piRst_n : clock, async active-low reset
//   bus (slave)    : key in, hash out, cfg write, init done
module toe_hash_pipe import toe_hash_pkg::*; #(
  parameter int           K    = K_DEF,
  parameter int           H    = H_DEF,
  parameter int           NH   = NH_DEF,
  parameter logic [K-1:0] SEED = K'(SEED_DEF)
) (
  input  logic            piClk,
  input  logic            piRst_n,
  toe_hash_pipe_if.slave  bus
);
  localparam int NROWS  = NH * H;
  localparam int AW     = addr_w(NROWS);
  localparam int STAGES = 2;

  state_e         state_q, state_d;
  logic [AW-1:0]  init_cnt;
  logic [K-1:0]   gen_q;
  logic [K-1:0]   mask_q [NROWS];

  logic [NROWS-1:0]  lo_par, hi_par;
  logic [NROWS-1:0]  s1_lo, s1_hi;
  logic [7:0]        s1_tag;
  logic [NROWS-1:0]  hash_q;
  logic [7:0]        tag_q;
  logic [STAGES:1]   vld_pipe;

  logic run, s2_adv, key_r, cfg_hit;

  // ---------------- init / run FSM ----------------
  always_ff @(posedge piClk or negedge piRst_n) begin
    if (!piRst_n) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
      gen_q    <= SEED;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        gen_q    <= K'(xs_step(KMAX'(gen_q), K));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt == AW'(NROWS - 1)) state_d = ST_RUN;
  end

  assign run = (state_q == ST_RUN);

  // ---------------- mask table ----------------
  // Extra leading zero keeps the bound check correct when NROWS == 2**AW.
  assign cfg_hit = ({1'b0, bus.piCfg_Addr} < (AW+1)'(NROWS));

  // No reset: every row is rewritten during INIT. A key accepted in the
  // same cycle as a write samples the old row, since the hash reads mask_q
  // combinationally before the edge.
  always_ff @(posedge piClk) begin
    if (state_q == ST_INIT)
      mask_q[init_cnt] <= gen_q;
    else if (bus.piCfg_We && cfg_hit)
      mask_q[bus.piCfg_Addr] <= bus.piCfg_Data;
  end

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    toe_hash_row #(.K(K)) u_row (
      .key    (bus.piKey_Data),
      .row    (mask_q[r]),
      .lo_par (lo_par[r]),
      .hi_par (hi_par[r])
    );
  end

  // ---------------- two-stage pipeline ----------------
  assign s2_adv = !vld_pipe[2] || bus.piHash_R;
  assign key_r  = run && (!vld_pipe[1] || s2_adv);

  always_ff @(posedge piClk or negedge piRst_n) begin
    if (!piRst_n) begin
      vld_pipe <= '0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_tag   <= '0;
      hash_q   <= '0;
      tag_q    <= '0;
    end else begin
      // key_r already implies stage 1 is free or draining this cycle
      if (key_r) begin
        vld_pipe[1] <= bus.piKey_V;
        if (bus.piKey_V) begin
          s1_lo  <= lo_par;
          s1_hi  <= hi_par;
          s1_tag <= bus.piKey_Tag;
        end
      end
      // data only loads with a real item so a stalled output never moves
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          hash_q <= s1_lo ^ s1_hi;
          tag_q  <= s1_tag;
        end
      end
    end
  end

  assign bus.poKey_R     = key_r;
  assign bus.poHash_V    = vld_pipe[2];
  assign bus.poHash_Data = hash_q;
  assign bus.poHash_Tag  = tag_q;
  assign bus.poInitDone  = run;

endmodule

// File: tb/tb_toe_hash_pipe.sv
// Self-checking bench for toe_hash_pipe: default instance (K=97,H=48,NH=2)
// for directed and table-driven checks, small instance (K=64,H=16,NH=3)
// for a long random run against a plain-arithmetic reference model.
module tb_toe_hash_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  toe_hash_pipe_if #(.K(97), .H(48), .NH(2)) a ();
  toe_hash_pipe_if #(.K(64), .H(16), .NH(3)) b ();

  toe_hash_pipe #(.K(97), .H(48), .NH(2), .SEED(97'h1)) dut (
    .piClk(clk), .piRst_n(rst_n), .bus(a.slave));
  toe_hash_pipe #(.K(64), .H(16), .NH(3), .SEED(64'h1)) dut_s (
    .piClk(clk), .piRst_n(rst_n), .bus(b.slave));

  int errs = 0;
  int checks = 0;

  // reference mask tables (rows kept in a wide container, low K bits used)
  logic [127:0] big_rows [96];
  logic [127:0] small_rows [48];

  typedef struct {
    logic [96:0] key;
    logic [7:0]  tag;
    logic [95:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] m_step(input logic [127:0] x, input int k);
    logic [127:0] one, m;
    one = 128'd1;
    m = (k >= 128) ? '1 : ((one << k) - one);
    x = (x ^ (x << 13)) & m;
    x = x ^ (x >> 7);
    x = (x ^ (x << 17)) & m;
    return x;
  endfunction

  task automatic gen_model();
    logic [127:0] x;
    x = 128'd1;
    for (int r = 0; r < 96; r++) begin big_rows[r] = x; x = m_step(x, 97); end
    x = 128'd1;
    for (int r = 0; r < 48; r++) begin small_rows[r] = x; x = m_step(x, 64); end
  endtask

  function automatic logic [95:0] hash_big(input logic [96:0] key);
    logic [95:0] h;
    for (int r = 0; r < 96; r++) h[r] = ^(key & big_rows[r][96:0]);
    return h;
  endfunction

  function automatic logic [47:0] hash_small(input logic [63:0] key);
    logic [47:0] h;
    for (int r = 0; r < 48; r++) h[r] = ^(key & small_rows[r][63:0]);
    return h;
  endfunction

  function automatic logic [96:0] rkey();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[96:0];
  endfunction

  // Called at a negedge; returns just after the edge where the result
  // became visible (lat = negedges from accept edge to poHash_V).
  task automatic send_big(input logic [96:0] key, input logic [7:0] tag,
                          output logic [95:0] hd, output logic [7:0] ht, output int lat);
    int n;
    a.piKey_Data = key; a.piKey_Tag = tag; a.piKey_V = 1'b1; a.piHash_R = 1'b1;
    n = 0;
    while (!a.poKey_R && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    a.piKey_V = 1'b0;
    lat = 1;
    while (!a.poHash_V && lat < 20) begin @(negedge clk); lat++; end
    hd = a.poHash_Data; ht = a.poHash_Tag;
  endtask

  task automatic cfg_write(input int addr, input logic [96:0] d);
    a.piCfg_We = 1'b1; a.piCfg_Addr = 7'(addr); a.piCfg_Data = d;
    @(negedge clk);
    a.piCfg_We = 1'b0;
    if (addr < 96) big_rows[addr] = {31'b0, d};
  endtask

  // Called at the negedge where reset is released.
  task automatic wait_init(input string nm);
    int n, ns;
    bit bad_r, bad_v;
    n = 0; ns = -1; bad_r = 0; bad_v = 0;
    while (!a.poInitDone && n < 400) begin
      if (a.poKey_R) bad_r = 1;
      if (a.poHash_V) bad_v = 1;
      @(posedge clk); #1; n++;
      if (b.poInitDone && ns < 0) ns = n;
    end
    chk({nm, "_init_cycles"}, n, 96);
    chk({nm, "_small_init_cycles"}, ns, 48);
    chk({nm, "_ready_in_init"}, bad_r, 0);
    chk({nm, "_hashv_in_init"}, bad_v, 0);
    @(negedge clk);
  endtask

  logic [95:0] hd, e1, e2, hold_d;
  logic [7:0]  ht, hold_t;
  int lat, di, oi, cyc, sent, got;
  bit acc, take, stall_prev;
  logic [96:0] skeys [10];
  logic [96:0] k97, oh;
  logic [63:0] k64;
  logic [47:0] q_h [$];
  logic [7:0]  q_t [$];

  initial begin
    a.piKey_Data = '0; a.piKey_Tag = '0; a.piKey_V = 0; a.piHash_R = 1;
    a.piCfg_We = 0; a.piCfg_Addr = '0; a.piCfg_Data = '0;
    b.piKey_Data = '0; b.piKey_Tag = '0; b.piKey_V = 0; b.piHash_R = 1;
    b.piCfg_We = 0; b.piCfg_Addr = '0; b.piCfg_Data = '0;
    gen_model();

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_hash_v", a.poHash_V, 0);
    chk("rst_key_r", a.poKey_R, 0);
    chk("rst_init_done", a.poInitDone, 0);
    chk("rst_hash_data", a.poHash_Data, 0);
    chk("rst_hash_tag", a.poHash_Tag, 0);
    chk("rst_small_init_done", b.poInitDone, 0);
    rst_n = 1'b1;
    wait_init("init");

    // ---- generated masks: row 0 is the seed ----
    send_big(97'h1, 8'h11, hd, ht, lat);
    chk("row0_bit0", hd[0], 1);
    chk("row0_hash", hd, hash_big(97'h1));
    chk("row0_tag", ht, 8'h11);
    for (int i = 0; i < 4; i++) begin
      k97 = rkey();
      send_big(k97, 8'(i + 8'h20), hd, ht, lat);
      chk("gen_mask_hash", hd, hash_big(k97));
      chk("gen_mask_lat", lat, 2);
    end

    // ---- one-hot rows, table-driven vectors ----
    for (int r = 0; r < 96; r++) begin
      oh = '0; oh[r] = 1'b1;
      cfg_write(r, oh);
    end
    vt[0] = '{97'h1_0000_0000_0000_0000_0000_ABCD, 8'hA1, 96'hABCD};
    vt[1] = '{97'h0_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'h02, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    vt[2] = '{97'h1_8000_0000_0000_0000_0000_0001, 8'h03, 96'h8000_0000_0000_0000_0000_0001};
    vt[3] = '{97'h0_1234_5678_9ABC_DEF0_0F0F_F0F0, 8'hFF, 96'h1234_5678_9ABC_DEF0_0F0F_F0F0};
    vt[4] = '{97'h1_0000_0000_0000_0000_0000_0000, 8'h00, 96'h0};
    for (int i = 0; i < 5; i++) begin
      send_big(vt[i].key, vt[i].tag, hd, ht, lat);
      chk("vec_hash", hd, vt[i].exp);
      chk("vec_tag", ht, vt[i].tag);
      chk("vec_lat", lat, 2);
    end

    // out-of-range row addresses are ignored
    cfg_write(96, '1);
    cfg_write(127, '1);
    send_big(vt[0].key, 8'h5A, hd, ht, lat);
    chk("oob_cfg_hash", hd, 96'hABCD);

    // ---- stream of 10 with stall in cycles 3..6 ----
    for (int i = 0; i < 10; i++) skeys[i] = rkey();
    @(negedge clk);
    di = 0; oi = 0; cyc = 0; stall_prev = 0;
    while (oi < 10 && cyc < 100) begin
      if (stall_prev) begin
        chk("stall_v", a.poHash_V, 1);
        chk("stall_data", a.poHash_Data, hold_d);
        chk("stall_tag", a.poHash_Tag, hold_t);
      end
      a.piKey_V = (di < 10);
      if (di < 10) begin a.piKey_Data = skeys[di]; a.piKey_Tag = 8'(di); end
      a.piHash_R = !(cyc >= 3 && cyc <= 6);
      #1;
      acc  = a.piKey_V && a.poKey_R;
      take = a.poHash_V && a.piHash_R;
      stall_prev = a.poHash_V && !a.piHash_R;
      hold_d = a.poHash_Data; hold_t = a.poHash_Tag;
      if (take) begin
        if (oi < 10) begin
          chk("stream_data", a.poHash_Data, skeys[oi][95:0]);
          chk("stream_tag", a.poHash_Tag, 8'(oi));
        end
        oi++;
      end
      @(posedge clk);
      if (acc) di++;
      @(negedge clk);
      cyc++;
    end
    a.piKey_V = 0; a.piHash_R = 1;
    chk("stream_out_count", oi, 10);
    chk("stream_in_count", di, 10);
    for (int i = 0; i < 3; i++) begin
      chk("stream_no_dup", a.poHash_V, 0);
      @(negedge clk);
    end

    // ---- cfg write in the same cycle as accept ----
    cfg_write(0, 97'h2);
    a.piCfg_We = 1; a.piCfg_Addr = '0; a.piCfg_Data = '1;
    a.piKey_V = 1; a.piKey_Data = 97'h1; a.piKey_Tag = 8'h71; a.piHash_R = 1;
    #1;
    chk("cw_ready1", a.poKey_R, 1);
    e1 = hash_big(97'h1);
    @(negedge clk);
    a.piCfg_We = 0; big_rows[0] = {31'b0, {97{1'b1}}}; a.piKey_Tag = 8'h72;
    #1;
    chk("cw_ready2", a.poKey_R, 1);
    e2 = hash_big(97'h1);
    @(negedge clk);
    a.piKey_V = 0;
    chk("cw_old_v", a.poHash_V, 1);
    chk("cw_old_tag", a.poHash_Tag, 8'h71);
    chk("cw_old_bit0", a.poHash_Data[0], 0);
    chk("cw_old_hash", a.poHash_Data, e1);
    @(negedge clk);
    chk("cw_new_v", a.poHash_V, 1);
    chk("cw_new_tag", a.poHash_Tag, 8'h72);
    chk("cw_new_bit0", a.poHash_Data[0], 1);
    chk("cw_new_hash", a.poHash_Data, e2);
    @(negedge clk);

    // ---- reset with two keys in flight ----
    a.piHash_R = 0; a.piKey_V = 1; a.piKey_Data = rkey(); a.piKey_Tag = 8'h81;
    @(negedge clk);
    a.piKey_Data = rkey(); a.piKey_Tag = 8'h82;
    @(negedge clk);
    a.piKey_V = 0;
    chk("inflight_v", a.poHash_V, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hash_v", a.poHash_V, 0);
    chk("midrst_key_r", a.poKey_R, 0);
    chk("midrst_init_done", a.poInitDone, 0);
    chk("midrst_hash_data", a.poHash_Data, 0);
    a.piHash_R = 1;
    @(negedge clk); @(negedge clk);
    // keys and cfg writes offered during INIT must be ignored
    a.piCfg_We = 1; a.piCfg_Addr = 7'd5; a.piCfg_Data = rkey();
    a.piKey_V = 1; a.piKey_Data = rkey();
    rst_n = 1'b1;
    wait_init("reinit");
    a.piCfg_We = 0; a.piKey_V = 0;
    gen_model();
    for (int i = 0; i < 4; i++) begin
      k97 = rkey();
      send_big(k97, 8'(i + 8'h90), hd, ht, lat);
      chk("reinit_hash", hd, hash_big(k97));
      chk("reinit_tag", ht, 8'(i + 8'h90));
    end
    @(negedge clk);

    // ---- small instance: 10000 random keys, random backpressure ----
    sent = 0; got = 0; cyc = 0;
    while (got < 10000 && cyc < 60000) begin
      if (sent < 10000 && !b.piKey_V && $urandom_range(0, 3) != 0) begin
        k64 = {$urandom(), $urandom()};
        b.piKey_Data = k64; b.piKey_Tag = 8'(sent); b.piKey_V = 1;
      end
      b.piHash_R = ($urandom_range(0, 3) != 0);
      #1;
      acc  = b.piKey_V && b.poKey_R;
      take = b.poHash_V && b.piHash_R;
      if (take) begin
        if (q_h.size() == 0) chk("rand_unexpected_out", 1, 0);
        else begin
          chk("rand_hash", b.poHash_Data, q_h.pop_front());
          chk("rand_tag", b.poHash_Tag, q_t.pop_front());
        end
        got++;
      end
      if (acc) begin
        q_h.push_back(hash_small(b.piKey_Data));
        q_t.push_back(b.piKey_Tag);
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) b.piKey_V = 0;
      cyc++;
    end
    chk("rand_count", got, 10000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
